// File: rtl/seq_compare_unit.sv
// Multi-cycle comparator that walks the operands CHUNK bits per cycle, MSB chunk first; signed modes are turned into unsigned compares by flipping the sign bit at latch time.
// Results take k cycles (1..NCHUNK) and are held in DONE until out_ready; a new request is accepted only in IDLE.
module seq_compare_unit #(
  parameter int WIDTH      = 64,
  parameter int CHUNK      = 8,
  parameter int EARLY_EXIT = 1,
  localparam int NCHUNK    = WIDTH / CHUNK,
  localparam int CW        = $clog2(NCHUNK) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             result,
  output logic             lt,
  output logic             eq,
  output logic [CW-1:0]    chunks
);

  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0]    IDX_TOP   = IW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] SIGN_FLIP = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] M_SLT  = 2'd0;
  localparam logic [1:0] M_SLTU = 2'd1;
  localparam logic [1:0] M_SEQ  = 2'd2;
  localparam logic [1:0] M_SGE  = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       r_mode;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IW-1:0]    r_idx;
  logic             r_fd;
  logic             r_lt;
  logic             r_eq;
  logic [CW-1:0]    r_chunks;

  logic [WIDTH-1:0] w_flip;
  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic             w_diff;

  assign w_flip = (mode == M_SLTU) ? '0 : SIGN_FLIP;

  // Operands shift left each RUN cycle, so the chunk at idx is always the top chunk.
  assign w_a_chunk = r_a[WIDTH-1 -: CHUNK];
  assign w_b_chunk = r_b[WIDTH-1 -: CHUNK];
  assign w_diff    = (w_a_chunk != w_b_chunk);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_mode   <= M_SLT;
      r_a      <= '0;
      r_b      <= '0;
      r_idx    <= IDX_TOP;
      r_fd     <= 1'b0;
      r_lt     <= 1'b0;
      r_eq     <= 1'b0;
      r_chunks <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a      <= a ^ w_flip;
            r_b      <= b ^ w_flip;
            r_mode   <= mode;
            r_idx    <= IDX_TOP;
            r_chunks <= '0;
            r_fd     <= 1'b0;
            r_lt     <= 1'b0;
            r_eq     <= 1'b0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_chunks <= r_chunks + 1'b1;
          r_a      <= r_a << CHUNK;
          r_b      <= r_b << CHUNK;
          if (w_diff && !r_fd) begin
            r_fd <= 1'b1;
            r_lt <= (w_a_chunk < w_b_chunk);
            r_eq <= 1'b0;
          end
          if ((EARLY_EXIT != 0) && w_diff) begin
            r_state <= S_DONE;
          end else if (r_idx == '0) begin
            // A difference in the final chunk counts as found, not as equal.
            if (!r_fd && !w_diff) begin
              r_eq <= 1'b1;
              r_lt <= 1'b0;
            end
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign lt        = r_lt;
  assign eq        = r_eq;
  assign chunks    = r_chunks;

  always_comb begin
    result = 1'b0;
    if (out_valid) begin
      case (r_mode)
        M_SLT, M_SLTU: result = r_lt;
        M_SEQ:         result = r_eq;
        default:       result = !r_lt;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_compare_unit.sv
// Drives an early-exit and a full-scan instance with identical requests and checks both against hand tables and a reference model.
module tb_seq_compare_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] a, b;
  logic [1:0]  mode;
  logic        out_ready;

  logic       in_ready1, out_valid1, result1, lt1, eq1;
  logic [3:0] chunks1;
  logic       in_ready0, out_valid0, result0, lt0, eq0;
  logic [3:0] chunks0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_compare_unit #(.WIDTH(64), .CHUNK(8), .EARLY_EXIT(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid1), .out_ready(out_ready),
    .result(result1), .lt(lt1), .eq(eq1), .chunks(chunks1)
  );

  seq_compare_unit #(.WIDTH(64), .CHUNK(8), .EARLY_EXIT(0)) dut_full (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid0), .out_ready(out_ready),
    .result(result0), .lt(lt0), .eq(eq0), .chunks(chunks0)
  );

  typedef struct {
    logic [1:0]  m;
    logic [63:0] x;
    logic [63:0] y;
    logic        res;
    logic        lt;
    logic        eq;
    int          k;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic; k from the highest differing byte of a^b.
  function automatic void model(input logic [1:0] m, input logic [63:0] x, input logic [63:0] y,
                                output logic res, output logic l, output logic e, output int k);
    logic [63:0] d;
    logic        found;
    d = x ^ y;
    e = (x == y);
    l = (m == 2'd1) ? (x < y) : ($signed(x) < $signed(y));
    k = 8;
    found = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (!found && d[i*8 +: 8] != 8'd0) begin
        found = 1'b1;
        k = 8 - i;
      end
    end
    case (m)
      2'd0, 2'd1: res = l;
      2'd2:       res = e;
      default:    res = !l;
    endcase
  endfunction

  task automatic run_op(input string nm, input logic [1:0] m, input logic [63:0] x, input logic [63:0] y,
                        input logic er, input logic elt, input logic eeq, input int ek);
    logic       s1, s0, r1, l1v, e1, r0, l0v, e0;
    logic [3:0] c1, c0;
    int         lat1, lat0;
    s1 = 0; s0 = 0; lat1 = 0; lat0 = 0;
    r1 = 0; l1v = 0; e1 = 0; c1 = 0; r0 = 0; l0v = 0; e0 = 0; c0 = 0;
    @(negedge clk);
    in_valid = 1'b1; a = x; b = y; mode = m;
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~x; b = ~y; mode = ~m;
    chk({nm, "/in_ready_low"}, in_ready1, 1'b0);
    for (int c = 1; c <= 40 && !(s1 && s0); c++) begin
      @(posedge clk); #1;
      if (!s1 && out_valid1) begin
        s1 = 1; lat1 = c; r1 = result1; l1v = lt1; e1 = eq1; c1 = chunks1;
      end
      if (!s0 && out_valid0) begin
        s0 = 1; lat0 = c; r0 = result0; l0v = lt0; e0 = eq0; c0 = chunks0;
      end
    end
    chk({nm, "/ee_seen"}, s1, 1'b1);
    chk({nm, "/ee_latency"}, lat1, ek);
    chk({nm, "/ee_result"}, r1, er);
    chk({nm, "/ee_lt"}, l1v, elt);
    chk({nm, "/ee_eq"}, e1, eeq);
    chk({nm, "/ee_chunks"}, c1, ek);
    chk({nm, "/ee_held_result"}, result1, er);
    chk({nm, "/full_seen"}, s0, 1'b1);
    chk({nm, "/full_latency"}, lat0, 8);
    chk({nm, "/full_result"}, r0, er);
    chk({nm, "/full_lt"}, l0v, elt);
    chk({nm, "/full_eq"}, e0, eeq);
    chk({nm, "/full_chunks"}, c0, 8);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "/ee_ready_back"}, in_ready1, 1'b1);
    chk({nm, "/ee_valid_drop"}, out_valid1, 1'b0);
    chk({nm, "/full_ready_back"}, in_ready0, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       er, elt, eeq;
    int         ek, seen, spurious;
    logic [63:0] x, y, msk;
    logic [1:0]  m;

    tbl[0]  = '{2'd0, 64'd10,                 64'd20,                 1'b1, 1'b1, 1'b0, 8};
    tbl[1]  = '{2'd0, -64'sd10,               64'd5,                  1'b1, 1'b1, 1'b0, 1};
    tbl[2]  = '{2'd1, -64'sd10,               64'd5,                  1'b0, 1'b0, 1'b0, 1};
    tbl[3]  = '{2'd2, -64'sd20,               -64'sd20,               1'b1, 1'b0, 1'b1, 8};
    tbl[4]  = '{2'd3, -64'sd20,               -64'sd20,               1'b1, 1'b0, 1'b1, 8};
    tbl[5]  = '{2'd3, -64'sd5,                -64'sd10,               1'b1, 1'b0, 1'b0, 8};
    tbl[6]  = '{2'd1, 64'd1,                  64'd2,                  1'b1, 1'b1, 1'b0, 8};
    tbl[7]  = '{2'd0, 64'd20,                 64'd10,                 1'b0, 1'b0, 1'b0, 8};
    tbl[8]  = '{2'd3, 64'd5,                  -64'sd3,                1'b1, 1'b0, 1'b0, 1};
    tbl[9]  = '{2'd2, 64'h1234,               64'h1235,               1'b0, 1'b1, 1'b0, 8};
    tbl[10] = '{2'd1, 64'hFF00_0000_0000_0000, 64'h0100_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; mode = 2'd0;
    #1;
    chk("reset/in_ready", in_ready1, 1'b1);
    chk("reset/out_valid", out_valid1, 1'b0);
    chk("reset/result", result1, 1'b0);
    chk("reset/lt", lt1, 1'b0);
    chk("reset/eq", eq1, 1'b0);
    chk("reset/chunks", chunks1, 4'd0);
    chk("reset/full_in_ready", in_ready0, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_op($sformatf("tbl%0d", i), tbl[i].m, tbl[i].x, tbl[i].y,
             tbl[i].res, tbl[i].lt, tbl[i].eq, tbl[i].k);
    end

    // Backpressure: result held for 3 cycles while a competing request is offered.
    @(negedge clk);
    in_valid = 1'b1; a = 64'd20; b = 64'd10; mode = 2'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(posedge clk); #1;
      if (out_valid1) seen = 1;
    end
    chk("bp/seen", seen, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 64'd1; b = 64'd2; mode = 2'd1;
      @(posedge clk); #1;
      chk($sformatf("bp/out_valid%0d", i), out_valid1, 1'b1);
      chk($sformatf("bp/result%0d", i), result1, 1'b0);
      chk($sformatf("bp/chunks%0d", i), chunks1, 4'd8);
      chk($sformatf("bp/in_ready%0d", i), in_ready1, 1'b0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp/in_ready_back", in_ready1, 1'b1);
    chk("bp/out_valid_drop", out_valid1, 1'b0);
    @(posedge clk); #1;
    chk("bp/still_idle", in_ready1, 1'b1);

    // Reset in the middle of RUN aborts without a result.
    @(negedge clk);
    in_valid = 1'b1; a = 64'd7; b = 64'd7; mode = 2'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst/pre_chunks", chunks0, 4'd2);
    rst = 1'b1;
    #1;
    chk("rst/out_valid", out_valid1, 1'b0);
    chk("rst/chunks", chunks1, 4'd0);
    chk("rst/in_ready", in_ready1, 1'b1);
    chk("rst/full_chunks", chunks0, 4'd0);
    chk("rst/full_in_ready", in_ready0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (out_valid1 || out_valid0) spurious++;
    end
    chk("rst/no_result", spurious, 0);
    run_op("post_rst_sltu", 2'd1, 64'd1, 64'd2, 1'b1, 1'b1, 1'b0, 8);

    for (int i = 0; i < 150; i++) begin
      x   = {$urandom, $urandom};
      msk = {$urandom, $urandom} >> $urandom_range(0, 63);
      y   = ($urandom_range(0, 7) == 0) ? x : (x ^ msk);
      m   = 2'($urandom_range(0, 3));
      model(m, x, y, er, elt, eeq, ek);
      run_op($sformatf("rnd%0d", i), m, x, y, er, elt, eeq, ek);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
